pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Program-counter stage feeding SimpleCPU: holds the PC, drives the CPU's Input_Addr, and takes the CPU's
//  next address (Output_Addr) back. Run/step/halt FSM with commit enable, retired-instruction counter,
//  self-loop halt and address-fault trap. Top level ANDs cpu_en into the CPU's RegWrite/MemWrite paths.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//  IMEM_BYTES    1024           instruction-memory size in bytes; next_addr >= IMEM_BYTES is a fault
//  CNT_W         32             width of retired counter
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      level; enter/resume RUN from IDLE or HALT
//  step       in   1      level; commit exactly one instruction from IDLE or HALT
//  halt_req   in   1      level; stop after the current instruction commits
//  next_addr  in   32     next PC computed by the CPU (its Output_Addr)
//  bp_addr    in   32     breakpoint address (used only with PC_SEQ_BREAKPOINT_EN)
//  bp_valid   in   1      breakpoint armed (used only with PC_SEQ_BREAKPOINT_EN)
//  pc         out  32     current PC; drives the CPU's Input_Addr
//  cpu_en     out  1      combinational; high in cycles whose instruction commits
//  state      out  3      FSM state encoding (see package)
//  retired    out  CNT_W  count of committed instructions, saturating at all-ones
//  fault      out  1      sticky; set on bad next_addr
//  bp_hit     out  1      sticky until next start/step; breakpoint stopped execution
// BEHAVIOUR
//  Reset (async, any time, incl. mid-RUN): pc=RESET_VECTOR, state=IDLE, retired=0, fault=0, bp_hit=0, cpu_en=0.
//  States: IDLE=0, RUN=1, STEP=2, HALT=3, FAULT=4.
//  bad = next_addr[1:0]!=0 || next_addr>=IMEM_BYTES.
//  cpu_en = (state==RUN || state==STEP) && !bad && !bp_stop. No other state asserts cpu_en.
//  On posedge with cpu_en: pc<=next_addr; retired<=retired+1 unless already all-ones. Latency 1 cycle per instr.
//  IDLE: start -> RUN; else step -> STEP; start and step together: start wins. pc holds.
//  STEP: one cycle only; commits if cpu_en -> HALT. If bad -> FAULT instead.
//  RUN priority per cycle: bad -> FAULT (no commit, pc holds, fault<=1);
//    else bp_stop -> HALT (no commit, bp_hit<=1);
//    else commit and: halt_req or next_addr==pc (self-loop, e.g. j .) -> HALT; else stay RUN.
//  HALT: start -> RUN; else step -> STEP; start/step clear bp_hit. pc and retired hold.
//  FAULT: absorbing until rst; start/step/halt_req ignored; cpu_en=0.
//  halt_req in IDLE/HALT/FAULT: no effect. Self-loop in STEP: commits, goes HALT as usual.
// CONFIGURATION
//  PC_SEQ_BREAKPOINT_EN defined: bp_stop = bp_valid && pc==bp_addr && !skip_bp, evaluated in RUN only.
//    skip_bp is a 1-bit reg set on HALT->RUN transition, cleared after first RUN cycle, so resuming from
//    a breakpoint executes the instruction at bp_addr. STEP never honours breakpoints.
//  Undefined: bp_stop=0, bp_addr/bp_valid ignored, bp_hit tied 0. Ports identical in both builds.
// STRUCTURE
//  Package pc_seq_pkg: state localparams (IDLE..FAULT, 3-bit), PC_ALIGN_MASK=2'b11.
//  Sub-module sat_counter (#(W)): enable + async reset, saturating increment; instantiated for retired.
//  FSM, pc register and bad/self-loop compare live in pc_sequencer.
// TESTING
//  1 rst pulse mid-RUN at pc=0x10 -> pc=0, state=IDLE, retired=0 immediately (before next edge).
//  2 IDLE, start; next_addr=pc+4 for 5 cycles then next_addr=pc -> pc 0,4..0x14, retired=6, state=HALT.
//  3 HALT at pc=8, step with next_addr=0xC -> exactly one commit, pc=0xC, retired+1, state=HALT.
//  4 RUN, next_addr=0x402 (misaligned) -> cpu_en=0, fault=1, state=FAULT, pc holds; start ignored afterwards.
//  5 RUN, next_addr=IMEM_BYTES (0x400) -> FAULT; next_addr=0x3FC accepted -> commit.
//  6 (BREAKPOINT_EN) bp_addr=0x8, bp_valid=1, start -> HALT at pc=8, bp_hit=1, retired=2; start -> pc=0xC, bp_hit=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: state encoding and PC alignment mask shared by pc_sequencer and its bench
package pc_seq_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STEP  = 3'd2,
        HALT  = 3'd3,
        FAULT = 3'd4
    } state_t;
    localparam logic [1:0] PC_ALIGN_MASK = 2'b11;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: enabled up-counter with async reset that sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (en && !(&count)) count <= count + W'(1);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: SimpleCPU program-counter stage with run/step/halt FSM, retired counter and fault trap.
// Optional breakpoint logic is enabled by defining PC_SEQ_BREAKPOINT_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES   = 1024,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             halt_req,
    input  logic [31:0]      next_addr,
    input  logic [31:0]      bp_addr,
    input  logic             bp_valid,
    output logic [31:0]      pc,
    output logic             cpu_en,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             fault,
    output logic             bp_hit
);
    state_t st;
    logic   bad;
    logic   bp_stop;

    assign state  = st;
    assign bad    = |(next_addr[1:0] & PC_ALIGN_MASK) || next_addr >= IMEM_BYTES;
    assign cpu_en = (st == RUN || st == STEP) && !bad && !bp_stop;

`ifdef PC_SEQ_BREAKPOINT_EN
    logic skip_bp;
    // skip_bp lets a resume from a breakpoint execute the instruction sitting at bp_addr
    assign bp_stop = st == RUN && bp_valid && pc == bp_addr && !skip_bp;
    always_ff @(posedge clk or posedge rst)
        if (rst) skip_bp <= 1'b0;
        else skip_bp <= (st == HALT && start) ? 1'b1 : (st == RUN) ? 1'b0 : skip_bp;
`else
    logic unused_bp;
    assign bp_stop   = 1'b0;
    assign unused_bp = ^{bp_addr, bp_valid};
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            st     <= IDLE;
            pc     <= RESET_VECTOR;
            fault  <= 1'b0;
            bp_hit <= 1'b0;
        end else begin
            if (cpu_en) pc <= next_addr;
            case (st)
                IDLE: st <= start ? RUN : step ? STEP : IDLE;
                RUN: begin
                    if (bad) begin
                        st    <= FAULT;
                        fault <= 1'b1;
                    end else if (bp_stop) begin
                        st     <= HALT;
                        bp_hit <= 1'b1;
                    end else if (halt_req || next_addr == pc) st <= HALT;
                end
                STEP: begin
                    st <= bad ? FAULT : HALT;
                    if (bad) fault <= 1'b1;
                end
                HALT: begin
                    st <= start ? RUN : step ? STEP : HALT;
                    if (start || step) bp_hit <= 1'b0;
                end
                FAULT: st <= FAULT;
                default: st <= IDLE;
            endcase
        end

    sat_counter #(.W(CNT_W)) u_retired (
        .clk  (clk),
        .rst  (rst),
        .en   (cpu_en),
        .count(retired)
    );
endmodule
